kv_tier_directory: RTL
======================

Name: kv_tier_directory

Overview:
- Responder for the prefetch path's L1/L2 directory-check handshake.
- Answers "is this physical KV page already resident in L1 or L2, and in which tier" so the prefetcher can skip redundant DMA.
- Small fully-associative page-tag table. DMA completion and eviction logic maintain it through an update port.
- Sits between the prefetch core, the DMA engine completion path and the tier manager.

Parameters:
- NUM_ENTRIES, 16, number of directory entries (power of two, at least 2).
- ADDR_WIDTH, 64, physical address width.
- PAGE_SHIFT, 12, page size log2. Tag is addr[ADDR_WIDTH-1:PAGE_SHIFT].

Ports:
- clk  in  1  clock
- rst_n  in  1  reset
- dir_check_valid  in  1  lookup request valid
- dir_check_ready  out  1  lookup request accepted
- dir_check_addr  in  ADDR_WIDTH  physical address to look up
- dir_check_resp_valid  out  1  lookup response valid
- dir_check_resp_ready  in  1  response consumed
- dir_check_hit  out  1  1 = page resident in L1/L2
- dir_check_tier  out  2  0 = L1, 1 = L2, 2 = L3 (miss)
- upd_valid  in  1  table update valid
- upd_op  in  1  0 = install, 1 = invalidate
- upd_addr  in  ADDR_WIDTH  page address to update
- upd_tier  in  2  tier for install
- flush  in  1  one-cycle pulse, clear whole table
- occupancy  out  $clog2(NUM_ENTRIES)+1  count of valid entries (registered)

Behaviour:
- Reset: rst_n, synchronous, active-low; clock clk.
  - All entries invalid; round-robin pointer = 0.
  - dir_check_resp_valid = 0, dir_check_hit = 0, dir_check_tier = 0, occupancy = 0.
  - dir_check_ready = 0 while rst_n low.
- Entry contents: valid bit, tag, 1-bit tier (0 = L1, 1 = L2).
- Ready rule:
  - dir_check_ready = rst_n && (!dir_check_resp_valid || dir_check_resp_ready).
  - At most one response is held; the block accepts back-to-back lookups at one per cycle when the consumer keeps resp_ready high.
- Lookup timing:
  - On accept (valid && ready), compare the tag against all valid entries in parallel.
  - On the next cycle: dir_check_resp_valid = 1, hit = match, tier = matched entry tier, or 2'd2 on miss.
  - Latency is exactly 1 cycle from accept to resp_valid.
- Response hold: the response holds stable until resp_ready. resp_valid drops the cycle after a consume with no new accept.
- Update timing: updates are always accepted (no upd_ready) and take effect in the table on the cycle after upd_valid.
- Install:
  - If the tag is already present, overwrite its tier in place; occupancy unchanged.
  - Otherwise write the lowest-index invalid entry.
  - If the table is full, overwrite the entry at the round-robin pointer, then increment the pointer modulo NUM_ENTRIES. The pointer advances only on replacement.
- Install with upd_tier >= 2: treated as invalidate, since the directory tracks only L1/L2.
- Invalidate: clear the matching valid entry. No match = no effect.
- Same cycle, lookup accept and update to the same page: the lookup sees the pre-update table (read-before-write).
- flush:
  - Next cycle all entries are invalid, pointer = 0, occupancy = 0.
  - An update in the same cycle as flush is dropped.
  - A lookup accepted in the flush cycle sees the pre-flush table.
  - A held response is unaffected.
- Reset mid-operation: a held response is discarded and all table state is cleared.
- Duplicate tags: never created. Install always checks for a match first.

Optional Feature:
- Macro: KV_TIER_DIRECTORY_STATS_EN.
- When defined, adds outputs stat_hits and stat_misses, each 32 bits:
  - Counted on response consume (resp_valid && resp_ready).
  - Saturating at 32'hFFFFFFFF.
  - Cleared by reset and by flush.
- When undefined, the ports and counters do not exist, and behaviour is otherwise identical.

Test Plan:
1. Reset, then lookup 0x0000_1000 with resp_ready=1 -> resp_valid one cycle after accept; hit=0, tier=2; occupancy=0.
2. Install 0x0000_1000 as tier 0, install 0x0000_2ABC as tier 1, then look up 0x0000_1FFF and 0x0000_2000 back-to-back -> hit=1/tier=0, then hit=1/tier=1; occupancy=2; one accept per cycle.
3. Install 17 distinct pages with NUM_ENTRIES=16 -> 17th page replaces entry 0; lookup of page 1 misses, lookup of page 17 hits; occupancy stays 16; pointer = 1.
4. Hold resp_ready=0 for 3 cycles after a hit response -> dir_check_ready=0, response fields stable; a new lookup is accepted in the consume cycle.
5. Same cycle: lookup of 0x5000 and install of 0x5000 as tier 1 -> that lookup misses (tier 2); a lookup one cycle later hits with tier 1.
6. Flush concurrent with install of 0x6000, table at occupancy 3 -> next cycle occupancy=0, lookup of 0x6000 misses. With KV_TIER_DIRECTORY_STATS_EN defined, counters read 0 after flush.

Source files
------------

// File: rtl/kv_tier_directory.sv
// rtl/kv_tier_directory.sv - fully-associative L1/L2 page residency directory
// Optional hit/miss counters are built when KV_TIER_DIRECTORY_STATS_EN is defined.
module kv_tier_directory #(
   parameter int NUM_ENTRIES = 16,
   parameter int ADDR_WIDTH  = 64,
   parameter int PAGE_SHIFT  = 12
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         dir_check_valid,
   output logic                         dir_check_ready,
   input  logic [ADDR_WIDTH-1:0]        dir_check_addr,
   output logic                         dir_check_resp_valid,
   input  logic                         dir_check_resp_ready,
   output logic                         dir_check_hit,
   output logic [1:0]                   dir_check_tier,
   input  logic                         upd_valid,
   input  logic                         upd_op,
   input  logic [ADDR_WIDTH-1:0]        upd_addr,
   input  logic [1:0]                   upd_tier,
   input  logic                         flush,
   output logic [$clog2(NUM_ENTRIES):0] occupancy
`ifdef KV_TIER_DIRECTORY_STATS_EN
   ,
   output logic [31:0]                  stat_hits,
   output logic [31:0]                  stat_misses
`endif
);
   localparam int TAG_W = ADDR_WIDTH - PAGE_SHIFT;
   localparam int IDX_W = $clog2(NUM_ENTRIES);
   localparam logic [IDX_W:0]   OCC_ONE = 1;
   localparam logic [IDX_W-1:0] PTR_ONE = 1;

   logic [NUM_ENTRIES-1:0] ent_valid;
   logic [NUM_ENTRIES-1:0] ent_tier;
   logic [TAG_W-1:0]       ent_tag [NUM_ENTRIES];
   logic [IDX_W-1:0]       rr_ptr;

   logic [TAG_W-1:0] chk_tag;
   logic [TAG_W-1:0] upd_tag;
   logic             unused_offset_bits;
   assign chk_tag = dir_check_addr[ADDR_WIDTH-1:PAGE_SHIFT];
   assign upd_tag = upd_addr[ADDR_WIDTH-1:PAGE_SHIFT];
   assign unused_offset_bits = ^{dir_check_addr[PAGE_SHIFT-1:0], upd_addr[PAGE_SHIFT-1:0]};

   logic accept;
   assign dir_check_ready = rst_n && (!dir_check_resp_valid || dir_check_resp_ready);
   assign accept          = dir_check_valid && dir_check_ready;

   logic             chk_hit;
   logic             chk_tier_bit;
   logic             upd_hit;
   logic [IDX_W-1:0] upd_idx;
   logic             free_found;
   logic [IDX_W-1:0] free_idx;
   logic [IDX_W-1:0] wr_idx;
   logic             upd_inval;

   // Lookup match, update match and lowest free slot all read the pre-update table.
   always_comb begin
      chk_hit      = 1'b0;
      chk_tier_bit = 1'b0;
      upd_hit      = 1'b0;
      upd_idx      = '0;
      free_found   = 1'b0;
      free_idx     = '0;
      for (int i = 0; i < NUM_ENTRIES; i++) begin
         if (ent_valid[i] && ent_tag[i] == chk_tag) begin
            chk_hit      = 1'b1;
            chk_tier_bit = ent_tier[i];
         end
         if (ent_valid[i] && ent_tag[i] == upd_tag) begin
            upd_hit = 1'b1;
            upd_idx = IDX_W'(i);
         end
         if (!ent_valid[i] && !free_found) begin
            free_found = 1'b1;
            free_idx   = IDX_W'(i);
         end
      end
   end

   assign upd_inval = upd_op || upd_tier[1];
   assign wr_idx    = upd_hit ? upd_idx : (free_found ? free_idx : rr_ptr);

   always_ff @(posedge clk) begin
      if (!rst_n || flush) begin
         ent_valid <= '0;
         ent_tier  <= '0;
         rr_ptr    <= '0;
         occupancy <= '0;
      end else if (upd_valid) begin
         if (upd_inval) begin
            if (upd_hit) begin
               ent_valid[upd_idx] <= 1'b0;
               occupancy          <= occupancy - OCC_ONE;
            end
         end else begin
            ent_valid[wr_idx] <= 1'b1;
            ent_tag[wr_idx]   <= upd_tag;
            ent_tier[wr_idx]  <= upd_tier[0];
            if (!upd_hit) begin
               if (free_found) occupancy <= occupancy + OCC_ONE;
               else            rr_ptr    <= rr_ptr + PTR_ONE;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         dir_check_resp_valid <= 1'b0;
         dir_check_hit        <= 1'b0;
         dir_check_tier       <= 2'd0;
      end else if (accept) begin
         dir_check_resp_valid <= 1'b1;
         dir_check_hit        <= chk_hit;
         dir_check_tier       <= chk_hit ? {1'b0, chk_tier_bit} : 2'd2;
      end else if (dir_check_resp_ready) begin
         dir_check_resp_valid <= 1'b0;
      end
   end

`ifdef KV_TIER_DIRECTORY_STATS_EN
   logic consume;
   assign consume = dir_check_resp_valid && dir_check_resp_ready;

   always_ff @(posedge clk) begin
      if (!rst_n || flush) begin
         stat_hits   <= '0;
         stat_misses <= '0;
      end else if (consume) begin
         if (dir_check_hit && stat_hits != 32'hFFFF_FFFF)
            stat_hits <= stat_hits + 32'd1;
         if (!dir_check_hit && stat_misses != 32'hFFFF_FFFF)
            stat_misses <= stat_misses + 32'd1;
      end
   end
`endif
endmodule
